hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Consumer-side pipeline control for the 5-stage MIPS datapath.
- Takes stage register indices and control bits from ID/EX/MEM/WB, plus cache handshakes (ihit/dhit).
- Produces operand forwarding selects, per-latch enables and flushes, and PC enable.
- Holds a small FSM for data-memory wait and halt, plus a saturating stall-cycle counter.

Parameters:
CNT_W, 16, width of stall_cnt (saturating)

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous active-high reset
id_rs  input  5  rs of instruction in ID
id_rt  input  5  rt of instruction in ID
ex_rs  input  5  rs of instruction in EX
ex_rt  input  5  rt of instruction in EX
ex_wsel  input  5  destination reg of instruction in EX
ex_memread  input  1  EX instruction is a load
ex_branch_taken  input  1  branch/jump resolved taken in EX
mem_wsel  input  5  destination reg in MEM
mem_regwr  input  1  MEM instruction writes the register file
mem_dmemop  input  1  MEM instruction is a load or store (dREN|dWEN)
mem_halt  input  1  halt instruction in MEM
wb_wsel  input  5  destination reg in WB
wb_regwr  input  1  WB instruction writes the register file
ihit  input  1  instruction cache hit
dhit  input  1  data cache hit
fwd_a  output  2  fwd_sel_t for ALU port A
fwd_b  output  2  fwd_sel_t for ALU port B
pc_en  output  1  PC update enable
ifid_en, idex_en, exmem_en, memwb_en  output  1 each  latch enables
ifid_flush, idex_flush  output  1 each  synchronous bubble insert
halted  output  1  registered, sticky halt
stall_cnt  output  CNT_W  cycles with pc_en=0 while not halted

Behaviour:
- Clock/reset: the only clock is CLK. RST is asynchronous and active-high.
- Reset values: state=RUN, halted=0, stall_cnt=0. While RST=1, all enables and flushes are 0 and fwd_a=fwd_b=FWD_NONE.
- FSM states: RUN, MEMWAIT, HALT.
  - RUN→MEMWAIT: mem_dmemop & !dhit.
  - MEMWAIT→RUN: dhit.
  - RUN or MEMWAIT→HALT: mem_halt & !freeze, where freeze = mem_dmemop & !dhit.
  - HALT is left only by RST.
- Forwarding (combinational, independent of state):
  - fwd_a=FWD_MEM if mem_regwr & mem_wsel!=0 & mem_wsel==ex_rs.
  - else FWD_WB if wb_regwr & wb_wsel!=0 & wb_wsel==ex_rs.
  - else FWD_NONE.
  - fwd_b uses the same rule with ex_rt. MEM has priority over WB. $0 is never forwarded.
- Stall/flush priority (highest first, all combinational, same-cycle):
  1. HALT: all enables 0, flushes 0, halted=1.
  2. freeze: all four latch enables and pc_en are 0; flushes 0. Any pending branch/load-use is held, because EX and ID are frozen and re-present next cycle.
  3. ex_branch_taken:
     - pc_en=1, all latch enables=1.
     - ifid_flush=1, idex_flush=1.
     - Load-use is ignored, since the ID instruction is squashed.
  4. Load-use: ex_memread & ex_wsel!=0 & (ex_wsel==id_rs | ex_wsel==id_rt).
     - pc_en=0, ifid_en=0, idex_flush=1.
     - exmem_en=1, memwb_en=1.
     - Exactly one bubble; the load then sits in MEM, so the condition clears.
  5. !ihit: pc_en=0, ifid_flush=1; all other latches advance (bubble into ID).
  6. Otherwise all enables are 1 and flushes are 0.
- Flush with enable: a latch whose flush=1 has its enable=1 in the same cycle.
- halted: registered; rises the cycle after the RUN→HALT transition and stays high.
- stall_cnt:
  - Increments on each rising edge where state!=HALT & pc_en==0.
  - Saturates at all-ones (no wrap).
  - Frozen in HALT.
- Reset mid-MEMWAIT: returns to RUN at once and the counter clears.

Decomposition:
- cpu_types_pkg gains `typedef enum logic [1:0] {FWD_NONE=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10} fwd_sel_t;` and `typedef enum logic [1:0] {HZ_RUN, HZ_MEMWAIT, HZ_HALT} hz_state_t;`.
- A new hazard_stall_ctrl_if interface carries the ports, with modports hsc and tb.
- One natural sub-module is forward_sel: purely combinational, compares one source register against MEM/WB. It is instantiated twice, for A and B.

Test Plan:
1. Reset, then release with ihit=1, no hazards → all enables 1, fwd 00, stall_cnt=0, state RUN.
2. Forwarding priority: ex_rs=5, mem_wsel=5, mem_regwr=1, wb_wsel=5, wb_regwr=1 → fwd_a=01. Clear mem_regwr → fwd_a=10. Set ex_rs=0 with matching wsel=0 → fwd_a=00.
3. Load-use: ex_memread=1, ex_wsel=8, id_rt=8 → pc_en=0, ifid_en=0, idex_flush=1 for one cycle. Next cycle (ex_memread=0) normal; stall_cnt=1.
4. D-cache miss: mem_dmemop=1, dhit=0 for 3 cycles, then dhit=1 → all enables 0 for 3 cycles, state MEMWAIT. On the dhit cycle enables are 1 and the next state is RUN; stall_cnt=3. Assert ex_branch_taken during the miss → flushes held at 0 until the dhit cycle.
5. Halt: mem_halt=1 with dmemop=0 → next cycle halted=1 and all enables 0. Toggling inputs for 10 cycles changes nothing and stall_cnt is frozen. Async RST mid-cycle clears halted immediately.
6. Saturation with CNT_W=4: hold ihit=0 for 20 cycles → stall_cnt reaches 15 and stays there.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared types and helpers for the pipeline hazard/stall controller
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {FWD_NONE = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10} fwd_sel_t;
  typedef enum logic [1:0] {HZ_RUN, HZ_MEMWAIT, HZ_HALT} hz_state_t;

  localparam int REG_W = 5;

  // True when a writing stage targets src; $0 never counts as a producer.
  function automatic logic reg_hit(input logic wr, input logic [REG_W-1:0] wsel,
                                   input logic [REG_W-1:0] src);
    return wr && (wsel != '0) && (wsel == src);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - stage indices, cache handshakes and pipeline controls
interface hazard_stall_ctrl_if #(parameter int CNT_W = 16);
  import hazard_stall_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_wsel, mem_wsel, wb_wsel;
  logic             ex_memread, ex_branch_taken;
  logic             mem_regwr, mem_dmemop, mem_halt, wb_regwr;
  logic             ihit, dhit;
  fwd_sel_t         fwd_a, fwd_b;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, halted;
  logic [CNT_W-1:0] stall_cnt;

  modport hsc (
    input  id_rs, id_rt, ex_rs, ex_rt, ex_wsel, ex_memread, ex_branch_taken,
           mem_wsel, mem_regwr, mem_dmemop, mem_halt, wb_wsel, wb_regwr, ihit, dhit,
    output fwd_a, fwd_b, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, halted, stall_cnt
  );

  modport tb (
    output id_rs, id_rt, ex_rs, ex_rt, ex_wsel, ex_memread, ex_branch_taken,
           mem_wsel, mem_regwr, mem_dmemop, mem_halt, wb_wsel, wb_regwr, ihit, dhit,
    input  fwd_a, fwd_b, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, halted, stall_cnt
  );

endinterface

// File: rtl/hazard_stall_ctrl_forward_sel.sv
// rtl/hazard_stall_ctrl_forward_sel.sv - operand bypass select for one ALU source
module hazard_stall_ctrl_forward_sel
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src_i,
  input  logic [REG_W-1:0] mem_wsel_i,
  input  logic             mem_regwr_i,
  input  logic [REG_W-1:0] wb_wsel_i,
  input  logic             wb_regwr_i,
  output fwd_sel_t         sel_o
);

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    sel_o = FWD_NONE;
    if (reg_hit(mem_regwr_i, mem_wsel_i, src_i)) begin
      sel_o = FWD_MEM;
    end else if (reg_hit(wb_regwr_i, wb_wsel_i, src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - forwarding, stall/flush and halt control for the 5-stage pipeline
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic            CLK,
  input logic            RST,
  hazard_stall_ctrl_if.hsc bus
);

  hz_state_t        state_q, state_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             freeze, load_use;
  fwd_sel_t         fwd_a, fwd_b;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;

  assign freeze   = bus.mem_dmemop & ~bus.dhit;
  assign load_use = reg_hit(bus.ex_memread, bus.ex_wsel, bus.id_rs)
                  | reg_hit(bus.ex_memread, bus.ex_wsel, bus.id_rt);

  hazard_stall_ctrl_forward_sel u_fwd_a (
    .src_i(bus.ex_rs), .mem_wsel_i(bus.mem_wsel), .mem_regwr_i(bus.mem_regwr),
    .wb_wsel_i(bus.wb_wsel), .wb_regwr_i(bus.wb_regwr), .sel_o(fwd_a)
  );

  hazard_stall_ctrl_forward_sel u_fwd_b (
    .src_i(bus.ex_rt), .mem_wsel_i(bus.mem_wsel), .mem_regwr_i(bus.mem_regwr),
    .wb_wsel_i(bus.wb_wsel), .wb_regwr_i(bus.wb_regwr), .sel_o(fwd_b)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= HZ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HZ_RUN: begin
        if (bus.mem_halt && !freeze) state_d = HZ_HALT;
        else if (freeze)             state_d = HZ_MEMWAIT;
      end
      HZ_MEMWAIT: begin
        if (bus.mem_halt && !freeze) state_d = HZ_HALT;
        else if (bus.dhit)           state_d = HZ_RUN;
      end
      default: state_d = HZ_HALT;
    endcase
  end

  // Priority chain: halt, cache freeze, taken branch, load-use bubble, I-miss bubble.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (RST || state_q == HZ_HALT || freeze) begin
      pc_en = 1'b0;
    end else if (bus.ex_branch_taken) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      {idex_en, exmem_en, memwb_en} = '1;
      idex_flush = 1'b1;
    end else if (!bus.ihit) begin
      {ifid_en, idex_en, exmem_en, memwb_en} = '1;
      ifid_flush = 1'b1;
    end else begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
    end
  end

  assign halted_d = (state_d == HZ_HALT);
  assign cnt_d    = (state_q != HZ_HALT && !pc_en && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.fwd_a      = RST ? FWD_NONE : fwd_a;
  assign bus.fwd_b      = RST ? FWD_NONE : fwd_b;
  assign bus.pc_en      = pc_en;
  assign bus.ifid_en    = ifid_en;
  assign bus.idex_en    = idex_en;
  assign bus.exmem_en   = exmem_en;
  assign bus.memwb_en   = memwb_en;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_flush = idex_flush;
  assign bus.halted     = halted_q;
  assign bus.stall_cnt  = cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed checks of forwarding, stalls, halt and stall counter
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  localparam int CNT_W = 4;
  localparam logic [6:0] CTL_IDLE   = 7'b0000000;
  localparam logic [6:0] CTL_NORMAL = 7'b1111100;
  localparam logic [6:0] CTL_BRANCH = 7'b1111111;
  localparam logic [6:0] CTL_LDUSE  = 7'b0011101;
  localparam logic [6:0] CTL_IMISS  = 7'b0111110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_stall_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus.hsc)
  );

  wire [6:0] ctl = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                    bus.ifid_flush, bus.idex_flush};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_rs = '0; bus.id_rt = '0; bus.ex_rs = '0; bus.ex_rt = '0;
    bus.ex_wsel = '0; bus.mem_wsel = '0; bus.wb_wsel = '0;
    bus.ex_memread = 1'b0; bus.ex_branch_taken = 1'b0;
    bus.mem_regwr = 1'b0; bus.mem_dmemop = 1'b0; bus.mem_halt = 1'b0;
    bus.wb_regwr = 1'b0; bus.ihit = 1'b1; bus.dhit = 1'b1;
  endtask

  initial begin
    idle_inputs();
    // Forwarding match present during reset must still read FWD_NONE.
    bus.ex_rs = 5'd5; bus.mem_wsel = 5'd5; bus.mem_regwr = 1'b1;
    #2;
    check("rst_ctl", ctl, CTL_IDLE);
    check("rst_fwd_a", bus.fwd_a, FWD_NONE);
    check("rst_halted", bus.halted, 1'b0);
    check("rst_cnt", bus.stall_cnt, 0);
    #10;
    rst = 1'b0;
    idle_inputs();
    #1;
    check("run_ctl", ctl, CTL_NORMAL);
    check("run_fwd_a", bus.fwd_a, FWD_NONE);
    check("run_fwd_b", bus.fwd_b, FWD_NONE);
    check("run_state", dut.state_q, HZ_RUN);

    tick();
    bus.ex_rs = 5'd5; bus.mem_wsel = 5'd5; bus.mem_regwr = 1'b1;
    bus.wb_wsel = 5'd5; bus.wb_regwr = 1'b1;
    #1;
    check("fwd_a_mem_prio", bus.fwd_a, FWD_MEM);
    check("fwd_b_none", bus.fwd_b, FWD_NONE);
    bus.mem_regwr = 1'b0;
    #1;
    check("fwd_a_wb", bus.fwd_a, FWD_WB);
    bus.ex_rs = 5'd0; bus.mem_wsel = 5'd0; bus.wb_wsel = 5'd0;
    bus.mem_regwr = 1'b1; bus.wb_regwr = 1'b1;
    #1;
    check("fwd_a_zero", bus.fwd_a, FWD_NONE);
    bus.ex_rt = 5'd7; bus.mem_wsel = 5'd3; bus.wb_wsel = 5'd7;
    #1;
    check("fwd_b_wb", bus.fwd_b, FWD_WB);
    idle_inputs();

    // Load into $0 is no hazard.
    bus.ex_memread = 1'b1; bus.ex_wsel = 5'd0; bus.id_rs = 5'd0;
    #1;
    check("lduse_r0", ctl, CTL_NORMAL);
    bus.ex_wsel = 5'd8; bus.id_rs = 5'd0; bus.id_rt = 5'd8;
    #1;
    check("lduse_ctl", ctl, CTL_LDUSE);
    tick();
    bus.ex_memread = 1'b0;
    #1;
    check("lduse_after", ctl, CTL_NORMAL);
    check("lduse_cnt", bus.stall_cnt, 1);
    idle_inputs();

    tick();
    bus.mem_dmemop = 1'b1; bus.dhit = 1'b0; bus.ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("miss_ctl%0d", i), ctl, CTL_IDLE);
      tick();
      check($sformatf("miss_state%0d", i), dut.state_q, HZ_MEMWAIT);
    end
    bus.dhit = 1'b1;
    #1;
    check("dhit_ctl", ctl, CTL_BRANCH);
    tick();
    check("dhit_state", dut.state_q, HZ_RUN);
    check("dhit_cnt", bus.stall_cnt, 4);
    idle_inputs();

    bus.mem_halt = 1'b1;
    #1;
    check("halt_pre_ctl", ctl, CTL_NORMAL);
    check("halt_pre_halted", bus.halted, 1'b0);
    tick();
    check("halt_halted", bus.halted, 1'b1);
    check("halt_ctl", ctl, CTL_IDLE);
    for (int i = 0; i < 10; i++) begin
      bus.ihit = 1'($urandom); bus.dhit = 1'($urandom);
      bus.mem_dmemop = 1'($urandom); bus.ex_branch_taken = 1'($urandom);
      bus.ex_memread = 1'($urandom); bus.ex_wsel = 5'd9; bus.id_rs = 5'd9;
      bus.mem_halt = 1'($urandom);
      #1;
      check($sformatf("halt_hold_ctl%0d", i), ctl, CTL_IDLE);
      tick();
      check($sformatf("halt_hold_cnt%0d", i), bus.stall_cnt, 4);
      check($sformatf("halt_hold_flag%0d", i), bus.halted, 1'b1);
    end
    #2;
    rst = 1'b1;
    #1;
    check("halt_rst_halted", bus.halted, 1'b0);
    check("halt_rst_cnt", bus.stall_cnt, 0);
    check("halt_rst_state", dut.state_q, HZ_RUN);
    idle_inputs();
    #3;
    rst = 1'b0;

    tick();
    bus.ihit = 1'b0;
    #1;
    check("imiss_ctl", ctl, CTL_IMISS);
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("sat_cnt%0d", i), bus.stall_cnt, (i + 1 > 15) ? 15 : i + 1);
    end
    idle_inputs();

    // Halt is blocked while the data cache is still missing.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    bus.mem_halt = 1'b1; bus.mem_dmemop = 1'b1; bus.dhit = 1'b0;
    tick();
    check("halt_frz_state", dut.state_q, HZ_MEMWAIT);
    check("halt_frz_halted", bus.halted, 1'b0);
    bus.dhit = 1'b1;
    tick();
    check("halt_after_frz", bus.halted, 1'b1);
    check("halt_after_cnt", bus.stall_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
